// File: rtl/lcd_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_timing_gen
//  Purpose  : Free-running RGB-panel raster generator (HSYNC/VSYNC/DE, pixel
//             coordinates and line/frame start strobes) gated by a count enable.
//  Revision : 1.0  initial release
// ============================================================================
module lcd_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 13,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 29,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int X_W      = 11,
    parameter int Y_W      = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           line_start,
    output logic           frame_start
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync windows are expressed as inclusive [start, last] so that no constant
    // ever needs to represent H_TOTAL/V_TOTAL itself at counter width.
    localparam logic [X_W-1:0] c_h_last     = X_W'(c_h_total - 1);
    localparam logic [X_W-1:0] c_h_active   = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] c_hs_start   = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] c_hs_last    = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [Y_W-1:0] c_v_last     = Y_W'(c_v_total - 1);
    localparam logic [Y_W-1:0] c_v_active   = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] c_vs_start   = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] c_vs_last    = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic           c_hs_on      = (HS_POL != 0);
    localparam logic           c_vs_on      = (VS_POL != 0);

    if (c_h_total > (2 ** X_W)) begin : g_bad_x_w
        $error("lcd_timing_gen: X_W too narrow for H_TOTAL-1");
    end
    if (c_v_total > (2 ** Y_W)) begin : g_bad_y_w
        $error("lcd_timing_gen: Y_W too narrow for V_TOTAL-1");
    end
    if ((H_SYNC < 1) || (V_SYNC < 1)) begin : g_bad_sync
        $error("lcd_timing_gen: sync widths must be at least 1");
    end

    logic [X_W-1:0] r_h_cnt;
    logic [Y_W-1:0] r_v_cnt;

    logic           r_hsync;
    logic           r_vsync;
    logic           r_de;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic           r_line_start;
    logic           r_frame_start;

    logic w_h_vis;
    logic w_v_vis;
    logic w_de_next;
    logic w_hs_act;
    logic w_vs_act;
    logic w_line_start;

    always_comb begin
        w_h_vis      = (r_h_cnt < c_h_active);
        w_v_vis      = (r_v_cnt < c_v_active);
        w_de_next    = w_h_vis && w_v_vis;
        w_hs_act     = (r_h_cnt >= c_hs_start) && (r_h_cnt <= c_hs_last);
        w_vs_act     = (r_v_cnt >= c_vs_start) && (r_v_cnt <= c_vs_last);
        w_line_start = w_de_next && (r_h_cnt == '0);
    end

    // Raster position; v_cnt only advances on the h wrap, so vsync naturally
    // changes on line boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (en) begin
            if (r_h_cnt == c_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    // Outputs mirror the counters one cycle late; a frozen raster shows idle.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_hsync       <= ~c_hs_on;
            r_vsync       <= ~c_vs_on;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_hs_act ? c_hs_on : ~c_hs_on;
            r_vsync       <= w_vs_act ? c_vs_on : ~c_vs_on;
            r_de          <= w_de_next;
            r_x           <= w_de_next ? r_h_cnt : '0;
            r_y           <= w_de_next ? r_v_cnt : '0;
            r_line_start  <= w_line_start;
            r_frame_start <= w_line_start && (r_v_cnt == '0);
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcd_timing_gen
//  Purpose  : Scoreboard bench for lcd_timing_gen across default, small
//             active-high and zero-porch raster geometries.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lcd_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        ls;
        logic        fs;
        logic [10:0] x;
        logic [9:0]  y;
    } out_t;

    typedef struct packed {
        out_t d2;
        out_t d1;
        out_t d0;
    } trio_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    always #5 clk = ~clk;

    logic        hs0, vs0, de0, ls0, fs0;
    logic        hs1, vs1, de1, ls1, fs1;
    logic        hs2, vs2, de2, ls2, fs2;
    logic [10:0] x0, x1, x2;
    logic [9:0]  y0, y1, y2;

    lcd_timing_gen u_dut0 (
        .clk(clk), .rst(rst), .en(en), .hsync(hs0), .vsync(vs0), .de(de0),
        .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0)
    );

    lcd_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .hsync(hs1), .vsync(vs1), .de(de1),
        .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1)
    );

    lcd_timing_gen #(
        .H_ACTIVE(4), .H_FP(0), .H_SYNC(2), .H_BP(0),
        .V_ACTIVE(3), .V_FP(0), .V_SYNC(1), .V_BP(0),
        .HS_POL(0), .VS_POL(0)
    ) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .hsync(hs2), .vsync(vs2), .de(de2),
        .x(x2), .y(y2), .line_start(ls2), .frame_start(fs2)
    );

    // Geometry table: active, fp, sync, bp for h then v, then polarities.
    int ha[3], hf[3], hsn[3], hb[3], va[3], vf[3], vsn[3], vb[3];
    bit hp[3], vp[3];
    int pos[3];

    trio_t q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cycle    = 0;
    bit    drv_done = 0;

    // Reference: the raster is a linear pixel index within the frame; the
    // line/column and the segment it falls in follow from division.
    function automatic out_t model(input int d, input int p, input bit running);
        out_t o;
        int   ht, h, v;
        o    = '0;
        o.hs = ~hp[d];
        o.vs = ~vp[d];
        if (running) begin
            ht = ha[d] + hf[d] + hsn[d] + hb[d];
            h  = p % ht;
            v  = p / ht;
            if (h >= ha[d] + hf[d] && h - (ha[d] + hf[d]) < hsn[d]) o.hs = hp[d];
            if (v >= va[d] + vf[d] && v - (va[d] + vf[d]) < vsn[d]) o.vs = vp[d];
            if (h < ha[d] && v < va[d]) begin
                o.de = 1'b1;
                o.x  = 11'(h);
                o.y  = 10'(v);
                o.ls = (h == 0);
                o.fs = (h == 0) && (v == 0);
            end
        end
        return o;
    endfunction

    task automatic step(input bit r, input bit e);
        trio_t t;
        out_t  o[3];
        int    frame;
        @(negedge clk);
        rst = r;
        en  = e;
        for (int d = 0; d < 3; d++) begin
            frame = (ha[d] + hf[d] + hsn[d] + hb[d]) * (va[d] + vf[d] + vsn[d] + vb[d]);
            if (r) begin
                o[d]   = model(d, 0, 1'b0);
                pos[d] = 0;
            end else if (!e) begin
                o[d] = model(d, pos[d], 1'b0);
            end else begin
                o[d]   = model(d, pos[d], 1'b1);
                pos[d] = (pos[d] + 1) % frame;
            end
        end
        t.d0 = o[0];
        t.d1 = o[1];
        t.d2 = o[2];
        q.push_back(t);
    endtask

    task automatic compare(input int d, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL dut%0d cycle %0d: got hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d, expected hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d",
                     d, cycle, act.hs, act.vs, act.de, act.ls, act.fs, act.x, act.y,
                     exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.x, exp.y);
        end
    endtask

    // Monitor: every enabled edge yields one output sample per DUT.
    initial begin
        trio_t t;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                t = q.pop_front();
                compare(0, {hs0, vs0, de0, ls0, fs0, x0, y0}, t.d0);
                compare(1, {hs1, vs1, de1, ls1, fs1, x1, y1}, t.d1);
                compare(2, {hs2, vs2, de2, ls2, fs2, x2, y2}, t.d2);
                cycle++;
            end
        end
    end

    initial begin
        ha  = '{800, 4, 4}; hf  = '{40, 1, 0}; hsn = '{128, 2, 2}; hb = '{88, 1, 0};
        va  = '{480, 3, 3}; vf  = '{13, 1, 0}; vsn = '{3, 1, 1};   vb = '{29, 1, 0};
        hp  = '{0, 1, 0};   vp  = '{0, 1, 0};
        pos = '{0, 0, 0};

        // Reset, then two-plus full default lines of free running.
        repeat (3) step(1'b1, 1'b0);
        repeat (2200) step(1'b0, 1'b1);

        // Directed freeze: five idle cycles mid-line, then resume.
        repeat (5) step(1'b0, 1'b0);
        repeat (1200) step(1'b0, 1'b1);

        // Single-cycle reset mid-raster with en held high.
        step(1'b1, 1'b1);
        repeat (300) step(1'b0, 1'b1);

        // Randomized enable gaps and occasional resets.
        repeat (4000) step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
        repeat (200) step(1'b0, 1'b1);
        drv_done = 1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!drv_done && budget < 20000) begin
            @(posedge clk);
            budget++;
        end
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (!drv_done || q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: driver_done=%0d pending=%0d, expected driver_done=1 pending=0",
                     drv_done, q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
